// File: rtl/rvm_axi4_mem_ctrl_pkg.sv
// Shared types and constants for the rvm_core AXI4-lite memory controller.
package rvm_axi4_mem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Write payload captured when the core request is accepted
  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] b_en;
  } wr_req_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rvm_axi4_wr_chan.sv
// AW/W dual-handshake tracker: raises both VALIDs on start and drops each
// independently after its own handshake; done_c flags that both have completed.
module rvm_axi4_wr_chan (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic aw_ready,
  input  logic w_ready,
  output logic aw_valid,
  output logic w_valid,
  output logic done_c
);

  logic aw_done;
  logic w_done;
  logic aw_hs_c;
  logic w_hs_c;

  assign aw_hs_c = aw_valid && aw_ready;
  assign w_hs_c  = w_valid && w_ready;
  // Counts a handshake in the current cycle so simultaneous AW/W completion is seen at once
  assign done_c  = (aw_done || aw_hs_c) && (w_done || w_hs_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else if (start) begin
      aw_valid <= 1'b1;
      w_valid  <= 1'b1;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      if (aw_hs_c) begin
        aw_valid <= 1'b0;
        aw_done  <= 1'b1;
      end
      if (w_hs_c) begin
        w_valid <= 1'b0;
        w_done  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvm_axi4_mem_ctrl.sv
// Sequencing bridge from rvm_core's SRAM-style port to an AXI4-lite master, one transaction at a time.
// Define RVM_AXI_ERR_CAPTURE_EN to add the sticky err_valid/err_addr/err_clear error capture ports.
module rvm_axi4_mem_ctrl
  import rvm_axi4_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_c_en,
  input  logic              mem_w_en,
  input  logic [STRB_W-1:0] mem_b_en,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_error,
  output logic              mem_stall,
`ifdef RVM_AXI_ERR_CAPTURE_EN
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clear,
`endif
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [STRB_W-1:0] M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY
);

  state_e            state;
  state_e            next_state;
  logic [ADDR_W-1:0] addr_q;
  wr_req_t           wr_req_q;
  logic              ar_valid_q, r_ready_q, b_ready_q;
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;
  logic              ar_valid_d, r_ready_d, b_ready_d;
  logic [DATA_W-1:0] rdata_d;
  logic              error_d;
  logic              wr_start_c;
  logic              wr_done_c;
  logic              accept_c;
  logic              misaligned_c;

  assign accept_c     = (state == ST_IDLE) && mem_c_en;
  assign misaligned_c = (ALIGN_CHECK != 0) && is_misaligned(mem_addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (mem_c_en) begin
          if (misaligned_c)  next_state = ST_DONE;
          else if (mem_w_en) next_state = ST_WR_REQ;
          else               next_state = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (M_AXI_ARREADY) next_state = ST_RD_DATA;
      ST_RD_DATA: if (M_AXI_RVALID)  next_state = ST_DONE;
      ST_WR_REQ:  if (wr_done_c)     next_state = ST_WR_RESP;
      ST_WR_RESP: if (M_AXI_BVALID)  next_state = ST_DONE;
      ST_DONE:                       next_state = ST_IDLE;
      default:                       next_state = ST_IDLE;
    endcase
  end

  // Next-cycle values of the registered outputs, derived from the upcoming state
  always_comb begin
    ar_valid_d = (next_state == ST_RD_ADDR);
    r_ready_d  = (next_state == ST_RD_DATA);
    b_ready_d  = (next_state == ST_WR_RESP);
    wr_start_c = (state == ST_IDLE) && (next_state == ST_WR_REQ);
    rdata_d    = rdata_q;
    error_d    = error_q;
    if (accept_c) begin
      error_d = misaligned_c;
    end else if ((state == ST_RD_DATA) && M_AXI_RVALID) begin
      rdata_d = M_AXI_RDATA;
      error_d = (M_AXI_RRESP != AXI_RESP_OKAY);
    end else if ((state == ST_WR_RESP) && M_AXI_BVALID) begin
      error_d = (M_AXI_BRESP != AXI_RESP_OKAY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      b_ready_q  <= b_ready_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  // Request held for the whole AXI transaction, independent of the core's inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wr_req_q <= '0;
    end else if (accept_c) begin
      addr_q         <= mem_addr;
      wr_req_q.wdata <= mem_wdata;
      wr_req_q.b_en  <= mem_b_en;
    end
  end

  rvm_axi4_wr_chan u_wr_chan (
    .clk      (clk),
    .reset    (reset),
    .start    (wr_start_c),
    .aw_ready (M_AXI_AWREADY),
    .w_ready  (M_AXI_WREADY),
    .aw_valid (M_AXI_AWVALID),
    .w_valid  (M_AXI_WVALID),
    .done_c   (wr_done_c)
  );

  assign mem_stall     = mem_c_en && (state != ST_DONE);
  assign mem_rdata     = rdata_q;
  assign mem_error     = error_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARSIZE  = AXI_SIZE_WORD;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_RREADY  = r_ready_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWSIZE  = AXI_SIZE_WORD;
  assign M_AXI_WDATA   = wr_req_q.wdata;
  assign M_AXI_WSTRB   = wr_req_q.b_en;
  assign M_AXI_BREADY  = b_ready_q;

`ifdef RVM_AXI_ERR_CAPTURE_EN
  logic              err_event_c;
  logic [ADDR_W-1:0] err_src_c;

  // Misaligned errors complete straight from IDLE, before addr_q is loaded
  assign err_event_c = error_d && (next_state == ST_DONE) && (state != ST_DONE);
  assign err_src_c   = (state == ST_IDLE) ? mem_addr : addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_valid <= err_event_c || (err_valid && !err_clear);
      if (err_event_c && (!err_valid || err_clear)) err_addr <= err_src_c;
    end
  end
`endif

endmodule

// File: tb/tb_rvm_axi4_mem_ctrl.sv
// Randomized scoreboard bench for rvm_axi4_mem_ctrl with a behavioural AXI slave and memory model.
`timescale 1ns/1ps
module tb_rvm_axi4_mem_ctrl;

  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_c_en, mem_w_en, mem_error, mem_stall;
  logic [3:0]  mem_b_en;
  logic [31:0] M_AXI_ARADDR, M_AXI_RDATA, M_AXI_AWADDR, M_AXI_WDATA;
  logic [2:0]  M_AXI_ARSIZE, M_AXI_AWSIZE;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [1:0]  M_AXI_RRESP, M_AXI_BRESP;
  logic [3:0]  M_AXI_WSTRB;
`ifdef RVM_AXI_ERR_CAPTURE_EN
  logic        err_valid, err_clear;
  logic [31:0] err_addr;
`endif

  rvm_axi4_mem_ctrl #(.ADDR_W(ADDR_W), .ALIGN_CHECK(1)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_c_en(mem_c_en), .mem_w_en(mem_w_en),
    .mem_b_en(mem_b_en), .mem_rdata(mem_rdata), .mem_error(mem_error), .mem_stall(mem_stall),
`ifdef RVM_AXI_ERR_CAPTURE_EN
    .err_valid(err_valid), .err_addr(err_addr), .err_clear(err_clear),
`endif
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_be;
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, arv_cyc = 0, awv_cyc = 0, wv_cyc = 0;
  int exp_ar = 0, exp_aw = 0, exp_w = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Slave address map: the top region answers every access with SLVERR
  function automatic logic region_err(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  // One core request; returns the number of stalled cycles before the completion cycle
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [3:0] be, output int stalls);
    exp_t e;
    bit   seen;
    @(posedge clk); #1;
    mem_addr = a; mem_wdata = d; mem_w_en = we; mem_b_en = be; mem_c_en = 1'b1;
    cur_addr = a; cur_wdata = d; cur_be = be;
    if (a[1:0] != 2'b00) begin
      e.err = 1'b1;
    end else if (!we) begin
      model_rdata = ref_rd(a);
      e.err = region_err(a);
      exp_ar++;
    end else begin
      e.err = region_err(a);
      if (!e.err) ref_mem[a] = merge(ref_rd(a), d, be);
      exp_aw++; exp_w++;
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);
    stalls = 0;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (!mem_stall) seen = 1;
      else stalls++;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL request_timeout: addr 0x%08h still stalled after %0d cycles", a, stalls);
      summary();
      $finish;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_c_en = 1'b0;
      mem_addr = $urandom;
      mem_w_en = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: every completion cycle the core sees is checked against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_c_en && !mem_stall) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: completion with empty scoreboard at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("mem_error", 32'(mem_error), 32'(e.err));
          chk("mem_rdata", mem_rdata, e.rdata);
        end
      end
    end
  end

  // Behavioural AXI slave with per-channel programmable latency
  initial begin
    logic [31:0] rd_a, wr_a, wr_d;
    logic [3:0]  wr_s;
    logic        rd_pend, b_pend, aw_got, w_got;
    int          arw, rw, aww, ww, bw;
    rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    arw = 0; rw = 0; aww = 0; ww = 0; bw = 0;
    rd_a = 0; wr_a = 0; wr_d = 0; wr_s = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    forever begin
      @(posedge clk); #1;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
      M_AXI_RDATA = $urandom; M_AXI_RRESP = 2'($urandom_range(0, 3)); M_AXI_BRESP = 2'($urandom_range(0, 3));
      if (reset) begin
        rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        arw = 0; rw = 0; aww = 0; ww = 0; bw = 0;
      end else begin
        if (rd_pend) begin
          if (rw >= r_dly) begin
            M_AXI_RVALID = 1; M_AXI_RDATA = slv_rd(rd_a);
            M_AXI_RRESP = region_err(rd_a) ? 2'b10 : 2'b00;
            if (M_AXI_RREADY) rd_pend = 0;
          end else rw++;
        end
        if (b_pend) begin
          if (bw >= b_dly) begin
            M_AXI_BVALID = 1;
            M_AXI_BRESP = region_err(wr_a) ? 2'b10 : 2'b00;
            if (M_AXI_BREADY) begin
              b_pend = 0;
              if (!region_err(wr_a)) slv_mem[wr_a] = merge(slv_rd(wr_a), wr_d, wr_s);
            end
          end else bw++;
        end
        if (M_AXI_ARVALID) begin
          arv_cyc++;
          chk("araddr", M_AXI_ARADDR, cur_addr);
          chk("arsize", 32'(M_AXI_ARSIZE), 32'd2);
          arw++;
          if (arw > ar_dly) begin
            M_AXI_ARREADY = 1; ar_hs++; arw = 0; rd_pend = 1; rd_a = M_AXI_ARADDR; rw = 0;
          end
        end
        if (M_AXI_AWVALID) begin
          awv_cyc++;
          chk("awvalid_after_hs", 32'(aw_got), 32'd0);
          chk("awaddr", M_AXI_AWADDR, cur_addr);
          chk("awsize", 32'(M_AXI_AWSIZE), 32'd2);
          aww++;
          if (aww > aw_dly) begin
            M_AXI_AWREADY = 1; aw_hs++; aww = 0; aw_got = 1; wr_a = M_AXI_AWADDR;
          end
        end
        if (M_AXI_WVALID) begin
          wv_cyc++;
          chk("wvalid_after_hs", 32'(w_got), 32'd0);
          chk("wdata", M_AXI_WDATA, cur_wdata);
          chk("wstrb", 32'(M_AXI_WSTRB), 32'(cur_be));
          ww++;
          if (ww > w_dly) begin
            M_AXI_WREADY = 1; w_hs++; ww = 0; w_got = 1; wr_d = M_AXI_WDATA; wr_s = M_AXI_WSTRB;
          end
        end
        if (aw_got && w_got) begin
          b_pend = 1; bw = 0; aw_got = 0; w_got = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    n_cmp++; n_bad++;
    $display("FAIL global_timeout: simulation did not complete");
    summary();
    $finish;
  end

  initial begin
    int st, a0, aw0, w0, arv0, awv0, wv0;
    logic [31:0] a;
    bit ok;
    reset = 1; mem_c_en = 0; mem_addr = 0; mem_wdata = 0; mem_w_en = 0; mem_b_en = 0;
`ifdef RVM_AXI_ERR_CAPTURE_EN
    err_clear = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", 32'(M_AXI_ARVALID), 0); chk("rst_rready", 32'(M_AXI_RREADY), 0);
    chk("rst_awvalid", 32'(M_AXI_AWVALID), 0); chk("rst_wvalid", 32'(M_AXI_WVALID), 0);
    chk("rst_bready", 32'(M_AXI_BREADY), 0);   chk("rst_rdata", mem_rdata, 0);
    chk("rst_error", 32'(mem_error), 0);       chk("rst_stall", 32'(mem_stall), 0);
    @(posedge clk); #1; reset = 0;

    // Immediate-slave read of a known word
    ref_mem[32'h1000] = 32'hDEADBEEF; slv_mem[32'h1000] = 32'hDEADBEEF;
    arv0 = arv_cyc;
    issue(32'h0000_1000, 32'h0, 1'b0, 4'h0, st);
    chk("rd_min_stall", 32'(st), 32'd3);
    chk("rd_arvalid_cycles", 32'(arv_cyc - arv0), 32'd1);
    idle(2);

    // Write with W accepted two cycles before AW
    aw_dly = 2; w_dly = 0; awv0 = awv_cyc; wv0 = wv_cyc;
    issue(32'h0000_0010, 32'hA5A5_0000, 1'b1, 4'b1100, st);
    chk("wr_skew_stall", 32'(st), 32'd5);
    chk("wr_awvalid_cycles", 32'(awv_cyc - awv0), 32'd3);
    chk("wr_wvalid_cycles", 32'(wv_cyc - wv0), 32'd1);
    aw_dly = 0; idle(1);
    issue(32'h0000_0010, 32'h0, 1'b0, 4'h0, st);
    idle(1);

    // Slow ARREADY into a SLVERR region
    ar_dly = 5; arv0 = arv_cyc;
    issue(32'hF000_0100, 32'h0, 1'b0, 4'h0, st);
    chk("rd_slow_stall", 32'(st), 32'd8);
    chk("rd_slow_arvalid_cycles", 32'(arv_cyc - arv0), 32'd6);
    ar_dly = 0; idle(1);

    // Misaligned request never reaches AXI
    arv0 = arv_cyc; awv0 = awv_cyc;
    issue(32'h0000_0002, 32'h0, 1'b0, 4'h0, st);
    chk("misalign_stall", 32'(st), 32'd1);
    chk("misalign_no_axi", 32'(arv_cyc - arv0 + awv_cyc - awv0), 32'd0);
    idle(1);

    // Back-to-back write then read with mem_c_en held
    a0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
    issue(32'h0000_0020, 32'h1234_5678, 1'b1, 4'b1111, st);
    chk("b2b_wr_stall", 32'(st), 32'd3);
    issue(32'h0000_0020, 32'h0, 1'b0, 4'h0, st);
    chk("b2b_rd_stall_via_idle", 32'(st), 32'd3);
    chk("b2b_ar_hs", 32'(ar_hs - a0), 32'd1);
    chk("b2b_aw_hs", 32'(aw_hs - aw0), 32'd1);
    chk("b2b_w_hs", 32'(w_hs - w0), 32'd1);
    idle(1);

    // Reset while waiting in RD_DATA abandons the read
    r_dly = 10;
    @(posedge clk); #1;
    mem_addr = 32'h0000_0024; mem_w_en = 0; mem_c_en = 1; cur_addr = 32'h0000_0024;
    exp_ar++;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = M_AXI_RREADY;
    end
    chk("reach_rd_data", 32'(ok), 32'd1);
    @(posedge clk); #1; reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_arvalid", 32'(M_AXI_ARVALID), 0); chk("midrst_rready", 32'(M_AXI_RREADY), 0);
    chk("midrst_awvalid", 32'(M_AXI_AWVALID), 0); chk("midrst_wvalid", 32'(M_AXI_WVALID), 0);
    chk("midrst_bready", 32'(M_AXI_BREADY), 0);   chk("midrst_idle_stall", 32'(mem_stall), 1);
    chk("midrst_rdata", mem_rdata, 0);            chk("midrst_error", 32'(mem_error), 0);
    @(posedge clk); #1; reset = 0; mem_c_en = 0;
    model_rdata = 32'h0; r_dly = 0;
    issue(32'h0000_0020, 32'h0, 1'b0, 4'h0, st);
    chk("post_rst_rd_stall", 32'(st), 32'd3);
    idle(1);

`ifdef RVM_AXI_ERR_CAPTURE_EN
    chk("errcap_rst_valid", 32'(err_valid), 0);
    chk("errcap_rst_addr", err_addr, 0);
    issue(32'hF000_0200, 32'h0, 1'b0, 4'h0, st); idle(1);
    issue(32'hF000_0300, 32'h0, 1'b0, 4'h0, st); idle(1);
    @(negedge clk);
    chk("errcap_valid", 32'(err_valid), 1);
    chk("errcap_first_addr", err_addr, 32'hF000_0200);
    @(posedge clk); #1; err_clear = 1;
    @(posedge clk); #1; err_clear = 0;
    @(negedge clk);
    chk("errcap_cleared", 32'(err_valid), 0);
`endif

    // Randomized traffic over a small address pool
    for (int n = 0; n < 80; n++) begin
      a = (($urandom_range(0, 9) == 0) ? 32'hF000_0000 : 32'h0000_2000) + 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      issue(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), st);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(5);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("total_ar_hs", 32'(ar_hs), 32'(exp_ar));
    chk("total_aw_hs", 32'(aw_hs), 32'(exp_aw));
    chk("total_w_hs", 32'(w_hs), 32'(exp_w));
    summary();
    $finish;
  end

endmodule

// File: doc/rvm_axi4_mem_ctrl.md
Name: rvm_axi4_mem_ctrl

Overview:
- Sequencing controller between rvm_core's SRAM-style memory port and an AXI4(-lite subset) master interface. Replaces the combinational read-only bridge.
- Accepts one core request at a time and drives AR/R or AW/W/B handshakes through an FSM.
- Generates mem_stall until the response is captured, then returns registered rdata and error to the core.
- Instantiated inside rvm_core_axi4 between i_rvm_core and the M_AXI_* ports.

Parameters:
- ADDR_W, 32, width of mem_addr and the AXI address buses.
- ALIGN_CHECK, 1. When 1, a request with mem_addr[1:0]!=0 completes with mem_error=1 and no AXI transaction is issued.

Ports:
- clk  in  1  system/AXI clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- mem_addr  in  ADDR_W  core request address
- mem_wdata  in  32  core write data
- mem_c_en  in  1  core request valid
- mem_w_en  in  1  1=write, 0=read
- mem_b_en  in  4  byte enables
- mem_rdata  out  32  registered read data
- mem_error  out  1  registered error, valid in the cycle mem_stall=0 with mem_c_en=1
- mem_stall  out  1  core must hold its request stable while 1
- M_AXI_ARADDR out ADDR_W; M_AXI_ARSIZE out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1
- M_AXI_AWADDR out ADDR_W; M_AXI_AWSIZE out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Reset (reset=1 at clk edge):
  - State goes to IDLE.
  - All VALID/READY outputs, mem_rdata, mem_error and the internal aw_done/w_done flags clear to 0.
  - Reset mid-transaction abandons it; the interconnect shares the same reset.
- mem_stall = mem_c_en && (state != DONE). It is combinational from state and mem_c_en; all other outputs are registered.
- IDLE with mem_c_en=1:
  - Latch addr, wdata, b_en and w_en.
  - Misaligned address with ALIGN_CHECK=1: go to DONE with error=1.
  - Otherwise go to RD_ADDR if w_en=0, or WR_REQ if w_en=1.
- RD_ADDR:
  - ARVALID=1 with latched address; ARSIZE=3'b010 always.
  - Hold ARVALID and ARADDR until ARREADY; then go to RD_DATA.
- RD_DATA:
  - RREADY=1. On RVALID, capture RDATA into mem_rdata and set error = (RRESP!=2'b00); go to DONE.
- WR_REQ:
  - AWVALID and WVALID both assert on entry. WSTRB=latched b_en; AWSIZE=3'b010.
  - Each channel's VALID drops independently after its own handshake, tracked by aw_done/w_done.
  - Move to WR_RESP when both are done, including the case where both handshake in the same cycle.
  - WREADY before AWREADY and AWREADY before WREADY are both legal.
- WR_RESP:
  - BREADY=1. On BVALID, set error = (BRESP!=2'b00), leave mem_rdata unchanged, go to DONE.
- DONE:
  - Lasts exactly one cycle with mem_stall=0, in which the core consumes rdata/error.
  - Then go to IDLE unconditionally. Back-to-back requests therefore re-enter via IDLE, so a request is never issued twice.
- Minimum latency (READY/VALID asserted immediately by the slave):
  - Read: 4 cycles from mem_c_en rise to the stall=0 cycle.
  - Write: 4 cycles.
- mem_c_en dropping while busy (core protocol violation): the transaction completes on AXI, DONE still occurs, and the result is discarded.
- At most one outstanding transaction; no IDs and no bursts. Slave VALIDs arriving in unrelated states are ignored.

Optional Feature:
- Macro: RVM_AXI_ERR_CAPTURE_EN.
- When defined, adds three ports:
  - err_valid out 1: sticky, set on any error completion.
  - err_addr out ADDR_W: address of the first error; not overwritten while err_valid=1.
  - err_clear in 1: clears err_valid next cycle. If a new error coincides with err_clear, the new error wins and its address is captured.
- All three reset to 0.
- When undefined, these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Add to rvm_constants.v:
  - FSM state encodings (3-bit localparams).
  - AXI_RESP_OKAY=2'b00 and AXI_SIZE_WORD=3'b010.
- One sub-module: rvm_axi4_wr_chan, the AW/W dual-handshake tracker with aw_done/w_done flags. The top FSM sequences it.

Test Plan:
- Read 0x0000_1000, ARREADY and RVALID immediate, RDATA=0xDEADBEEF, RRESP=0 -> ARVALID exactly 1 cycle; mem_stall high 3 cycles then low 1 cycle; mem_rdata=0xDEADBEEF, mem_error=0.
- Write 0x10 with wdata 0xA5A5_0000 and b_en=4'b1100; WREADY 2 cycles before AWREADY; BRESP=0 -> WVALID drops after its handshake while AWVALID stays; WSTRB=1100; single DONE with error=0.
- Read with ARREADY delayed 5 cycles and RRESP=2'b10 (SLVERR) -> ARADDR stable throughout; mem_error=1 in the DONE cycle.
- mem_addr=0x0000_0002 with ALIGN_CHECK=1 -> no AR/AW VALID ever; mem_error=1 after 2 cycles.
- Back-to-back write then read (mem_c_en held high) -> exactly one AW, one W and one AR handshake; IDLE visited between the two requests.
- Assert reset during RD_DATA -> next cycle all VALID/READY=0 and state=IDLE; a subsequent read completes normally. With RVM_AXI_ERR_CAPTURE_EN, also check err_addr captures the first of two SLVERRs and err_clear resets err_valid.
